// File: rtl/simpleio_arb_pkg.sv
// Shared types and constants for the two-master simpleio arbiter.
package simpleio_arb_pkg;

  localparam int AW = 4;
  localparam int DW = 8;

  localparam logic M_CPU = 1'b0;
  localparam logic M_AUX = 1'b1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CMD  = 2'd1,
    DATA = 2'd2
  } state_e;

endpackage

// File: rtl/simpleio_arb_if.sv
// Per-master request/ack channel of the simpleio arbiter.
interface simpleio_arb_if;
  import simpleio_arb_pkg::*;

  logic          req;
  logic          rw;
  logic [AW-1:0] ad;
  logic [DW-1:0] wd;
  logic          ack;
  logic [DW-1:0] rd;

  modport master (output req, rw, ad, wd, input ack, rd);
  modport slave  (input req, rw, ad, wd, output ack, rd);

endinterface

// File: rtl/simpleio_arb_rr.sv
// Combinational 2-way round-robin picker; SIMPLEIO_ARB_LOCK_EN adds a lock override.
module simpleio_arb_rr
  import simpleio_arb_pkg::*;
(
  input  logic [1:0] req,
  input  logic       last_grant,
`ifdef SIMPLEIO_ARB_LOCK_EN
  input  logic [1:0] lock,
`endif
  output logic       valid,
  output logic       gnt_idx
);

  always_comb begin
    valid   = |req;
    gnt_idx = M_CPU;
    if (req == 2'b11) begin
      gnt_idx = ~last_grant;
    end else if (req[1]) begin
      gnt_idx = M_AUX;
    end
`ifdef SIMPLEIO_ARB_LOCK_EN
    // A locking master keeps the bus across back-to-back transfers.
    if (lock[last_grant] && req[last_grant]) begin
      gnt_idx = last_grant;
    end
`endif
  end

endmodule

// File: rtl/simpleio_arb.sv
// Two-master arbiter/sequencer for the simpleio register port: IDLE -> CMD (one cs) -> DATA (ack).
// Optional lock support via SIMPLEIO_ARB_LOCK_EN.
module simpleio_arb
  import simpleio_arb_pkg::*;
(
  input  logic          clk,
  input  logic          rst_n,
  simpleio_arb_if.slave m0,
  simpleio_arb_if.slave m1,
`ifdef SIMPLEIO_ARB_LOCK_EN
  input  logic          m0_lock,
  input  logic          m1_lock,
`endif
  output logic          io_cs,
  output logic          io_rw,
  output logic [AW-1:0] io_ad,
  output logic [DW-1:0] io_di,
  input  logic [DW-1:0] io_do,
  output logic          busy
);

  state_e        state_q, state_d;
  logic          last_grant_q, last_grant_d;
  logic          gnt_q, gnt_d;
  logic          io_rw_q, io_rw_d;
  logic [AW-1:0] io_ad_q, io_ad_d;
  logic [DW-1:0] io_di_q, io_di_d;

  logic          rr_valid;
  logic          rr_idx;

  simpleio_arb_rr u_rr (
    .req        ({m1.req, m0.req}),
    .last_grant (last_grant_q),
`ifdef SIMPLEIO_ARB_LOCK_EN
    .lock       ({m1_lock, m0_lock}),
`endif
    .valid      (rr_valid),
    .gnt_idx    (rr_idx)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      last_grant_q <= M_AUX;
      gnt_q        <= M_CPU;
      io_rw_q      <= 1'b1;
      io_ad_q      <= '0;
      io_di_q      <= '0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      gnt_q        <= gnt_d;
      io_rw_q      <= io_rw_d;
      io_ad_q      <= io_ad_d;
      io_di_q      <= io_di_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    gnt_d        = gnt_q;
    io_rw_d      = io_rw_q;
    io_ad_d      = io_ad_q;
    io_di_d      = io_di_q;
    io_cs        = 1'b0;
    m0.ack       = 1'b0;
    m1.ack       = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (rr_valid) begin
          state_d      = CMD;
          gnt_d        = rr_idx;
          last_grant_d = rr_idx;
          io_rw_d      = (rr_idx == M_AUX) ? m1.rw : m0.rw;
          io_ad_d      = (rr_idx == M_AUX) ? m1.ad : m0.ad;
          io_di_d      = (rr_idx == M_AUX) ? m1.wd : m0.wd;
        end
      end
      // The only state that strobes cs, so each grant yields exactly one access.
      CMD: begin
        io_cs   = 1'b1;
        state_d = DATA;
      end
      DATA: begin
        m0.ack  = (gnt_q == M_CPU);
        m1.ack  = (gnt_q == M_AUX);
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Peripheral DO is already registered, so read data is a straight pass-through.
  assign m0.rd = io_do;
  assign m1.rd = io_do;

  assign io_rw = io_rw_q;
  assign io_ad = io_ad_q;
  assign io_di = io_di_q;
  assign busy  = (state_q != IDLE);

endmodule

// File: tb/tb_simpleio_arb.sv
// Directed self-checking bench for simpleio_arb with a small simpleio register model.
module tb_simpleio_arb;
  import simpleio_arb_pkg::*;

  logic          clk   = 1'b0;
  logic          rst_n = 1'b1;
  logic          io_cs;
  logic          io_rw;
  logic [AW-1:0] io_ad;
  logic [DW-1:0] io_di;
  logic [DW-1:0] io_do;
  logic          busy;
`ifdef SIMPLEIO_ARB_LOCK_EN
  logic          m0_lock = 1'b0;
  logic          m1_lock = 1'b0;
`endif

  simpleio_arb_if m0_if ();
  simpleio_arb_if m1_if ();

  simpleio_arb dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .m0      (m0_if.slave),
    .m1      (m1_if.slave),
`ifdef SIMPLEIO_ARB_LOCK_EN
    .m0_lock (m0_lock),
    .m1_lock (m1_lock),
`endif
    .io_cs   (io_cs),
    .io_rw   (io_rw),
    .io_ad   (io_ad),
    .io_di   (io_di),
    .io_do   (io_do),
    .busy    (busy)
  );

  always #5 clk = ~clk;

  // Peripheral model: register file, registered DO, timer IRQ flag cleared by reading $08.
  logic [7:0] regs [16];
  logic [7:0] do_q    = 8'h00;
  logic       irq     = 1'b0;
  logic       irq_set = 1'b0;
  int         cs_cnt  = 0;

  always @(posedge clk) begin
    if (irq_set) irq <= 1'b1;
    if (io_cs) begin
      cs_cnt <= cs_cnt + 1;
      if (!io_rw) begin
        regs[io_ad] <= io_di;
      end else if (io_ad == 4'h8) begin
        do_q <= {irq, regs[8][6:0]};
        irq  <= 1'b0;
      end else begin
        do_q <= regs[io_ad];
      end
    end
  end
  assign io_do = do_q;

  int n_assert = 0;
  int n_fail   = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic set_m(input int m, input bit req, input bit rw,
                       input logic [3:0] ad, input logic [7:0] wd);
    if (m == 1) begin
      m1_if.req = req; m1_if.rw = rw; m1_if.ad = ad; m1_if.wd = wd;
    end else begin
      m0_if.req = req; m0_if.rw = rw; m0_if.ad = ad; m0_if.wd = wd;
    end
  endtask

  // Single transfer from master m, starting just after a falling edge with the bus idle.
  task automatic xfer(input int m, input bit rw, input logic [3:0] ad,
                      input logic [7:0] wd, input logic [7:0] exp_rd);
    int   c0;
    logic ack_m, ack_o;
    c0 = cs_cnt;
    set_m(m, 1'b1, rw, ad, wd);
    @(negedge clk);
    ack_m = (m == 1) ? m1_if.ack : m0_if.ack;
    chk("cmd_cs", io_cs, 1'b1);
    chk("cmd_rw", io_rw, rw);
    chk("cmd_ad", io_ad, ad);
    if (!rw) chk("cmd_di", io_di, wd);
    chk("cmd_noack", ack_m, 1'b0);
    chk("cmd_busy", busy, 1'b1);
    @(negedge clk);
    ack_m = (m == 1) ? m1_if.ack : m0_if.ack;
    ack_o = (m == 1) ? m0_if.ack : m1_if.ack;
    chk("data_cs", io_cs, 1'b0);
    chk("data_ack", ack_m, 1'b1);
    chk("data_other_ack", ack_o, 1'b0);
    if (rw) chk("data_rd", (m == 1) ? m1_if.rd : m0_if.rd, exp_rd);
    set_m(m, 1'b0, rw, ad, wd);
    @(negedge clk);
    ack_m = (m == 1) ? m1_if.ack : m0_if.ack;
    chk("idle_ack", ack_m, 1'b0);
    chk("idle_busy", busy, 1'b0);
    chk("cs_pulses", cs_cnt, c0 + 1);
    $display("xfer m%0d %s ad=%h wd=%h rd=%h", m, rw ? "RD" : "WR", ad, wd,
             (m == 1) ? m1_if.rd : m0_if.rd);
  endtask

  initial begin
    int c0;
    set_m(0, 1'b0, 1'b1, 4'h0, 8'h00);
    set_m(1, 1'b0, 1'b1, 4'h0, 8'h00);

    // Reset values
    #1 rst_n = 1'b0;
    #1;
    chk("rst_cs", io_cs, 1'b0);
    chk("rst_rw", io_rw, 1'b1);
    chk("rst_ad", io_ad, 4'h0);
    chk("rst_di", io_di, 8'h00);
    chk("rst_ack0", m0_if.ack, 1'b0);
    chk("rst_ack1", m1_if.ack, 1'b0);
    chk("rst_busy", busy, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;

    // Single write, then preload registers used by later reads
    xfer(0, 1'b0, 4'h1, 8'h5A, 8'h00);
    chk("led7hi", regs[1], 8'h5A);
    xfer(0, 1'b0, 4'hB, 8'h3C, 8'h00);
    xfer(0, 1'b0, 4'h8, 8'h05, 8'h00);

    // m1 read
    xfer(1, 1'b1, 4'hB, 8'h00, 8'h3C);

    // Timer IRQ read-to-clear: one strobe per read
    irq_set = 1'b1;
    @(negedge clk);
    irq_set = 1'b0;
    xfer(0, 1'b1, 4'h8, 8'h00, 8'h85);
    xfer(0, 1'b1, 4'h8, 8'h00, 8'h05);

    // Reset during CMD aborts without ack or completed strobe
    c0 = cs_cnt;
    set_m(0, 1'b1, 1'b0, 4'h2, 8'h77);
    @(negedge clk);
    chk("abort_cs_before", io_cs, 1'b1);
    #2 rst_n = 1'b0;
    #1;
    chk("abort_cs_drop", io_cs, 1'b0);
    chk("abort_busy", busy, 1'b0);
    chk("abort_ad", io_ad, 4'h0);
    set_m(0, 1'b0, 1'b0, 4'h2, 8'h77);
    @(negedge clk);
    chk("abort_ack0", m0_if.ack, 1'b0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("abort_ack0_post", m0_if.ack, 1'b0);
    chk("abort_no_strobe", cs_cnt, c0);
    xfer(1, 1'b1, 4'hB, 8'h00, 8'h3C);

    // Both masters held from reset: m0, m1, m0, m1 with acks 3 cycles apart
    rst_n = 1'b0;
    set_m(0, 1'b1, 1'b0, 4'h2, 8'h11);
    set_m(1, 1'b1, 1'b0, 4'h3, 8'h22);
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 1; k <= 12; k++) begin
      @(negedge clk);
      chk($sformatf("rr_ack0_c%0d", k), m0_if.ack, (k == 2 || k == 8));
      chk($sformatf("rr_ack1_c%0d", k), m1_if.ack, (k == 5 || k == 11));
      chk($sformatf("rr_cs_c%0d", k), io_cs, (k % 3 == 1));
      if (k % 3 == 1) chk($sformatf("rr_ad_c%0d", k), io_ad, (k == 1 || k == 7) ? 4'h2 : 4'h3);
    end
    set_m(0, 1'b0, 1'b0, 4'h2, 8'h11);
    set_m(1, 1'b0, 1'b0, 4'h3, 8'h22);
    @(negedge clk);
    chk("rr_idle_busy", busy, 1'b0);
    chk("rr_reg2", regs[2], 8'h11);
    chk("rr_reg3", regs[3], 8'h22);
    $display("xfer round-robin burst of 4 complete");

`ifdef SIMPLEIO_ARB_LOCK_EN
    // Lock: m1 keeps the bus for 3 transfers, then m0 wins after unlock
    xfer(0, 1'b0, 4'h4, 8'h44, 8'h00);
    set_m(0, 1'b1, 1'b0, 4'h5, 8'h55);
    set_m(1, 1'b1, 1'b0, 4'h6, 8'h66);
    m1_lock = 1'b1;
    for (int k = 1; k <= 11; k++) begin
      @(negedge clk);
      chk($sformatf("lk_ack1_c%0d", k), m1_if.ack, (k == 2 || k == 5 || k == 8));
      chk($sformatf("lk_ack0_c%0d", k), m0_if.ack, (k == 11));
      if (k == 8) m1_lock = 1'b0;
    end
    set_m(0, 1'b0, 1'b0, 4'h5, 8'h55);
    set_m(1, 1'b0, 1'b0, 4'h6, 8'h66);
    @(negedge clk);
    chk("lk_idle_busy", busy, 1'b0);
    chk("lk_reg5", regs[5], 8'h55);
    $display("xfer lock sequence complete");
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
